// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data access.
// Data wins ties unless fetch has lost STARVE_MAX consecutive contested grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              idle_s, fetch_turn_s, dm_gnt_s, if_gnt_s;

  // Grant decode: only in IDLE; fetch wins a tie once the starvation counter saturates.
  always_comb begin
    idle_s       = (state_q == IDLE);
    fetch_turn_s = if_req && (starve_q == STARVE_TOP);
    dm_gnt_s     = idle_s && dm_req && !fetch_turn_s;
    if_gnt_s     = idle_s && if_req && !dm_gnt_s;
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (dm_gnt_s) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + CNT_W'(1);
          end else begin
            starve_d = starve_q;
          end
        end else if (if_gnt_s) begin
          state_d     = I_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      I_BUSY: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end else begin
          state_d = I_BUSY;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          // Writes leave the last read result visible.
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else begin
          state_d = D_BUSY;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_s;
  assign dm_gnt    = dm_gnt_s;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_f   = (if_req & ~if_gnt_s) | (state_q == I_BUSY);
  assign stall_m   = (dm_req & ~dm_gnt_s) | (state_q == D_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected memory
// requests and read results; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        stall_m;

  logic        resp_ready;
  logic        man_ready;
  int          lat;
  int          checks;
  int          errors;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  bit          glog[$];
  logic [31:0] mem_arr[logic [31:0]];

  assign mem_ready = resp_ready | man_ready;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((mem_q.size() != 0 || if_q.size() != 0 || dm_q.size() != 0) && n < 40) begin
      next_cyc();
      n++;
    end
    check1(nm, (mem_q.size() == 0 && if_q.size() == 0 && dm_q.size() == 0), 1'b1);
  endtask

  // Memory model: answers mem_req after lat cycles; write responses carry junk read data.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    resp_ready = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      next_cyc();
      resp_ready = 1'b0;
      if (mem_req && !reset) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          resp_ready = 1'b1;
          wait_cnt   = 0;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            mem_rdata = ~mem_wdata;
          end else begin
            mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: logs grants and scores every memory request cycle and valid pulse.
  initial begin
    mreq_t m;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dm_gnt) glog.push_back(1'b0);
        if (if_gnt) glog.push_back(1'b1);
        if (if_valid) begin
          if (if_q.size() == 0) check1("if_valid_unexpected", if_valid, 1'b0);
          else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (dm_valid) begin
          if (dm_q.size() == 0) check1("dm_valid_unexpected", dm_valid, 1'b0);
          else check("dm_rdata", dm_rdata, dm_q.pop_front());
        end
        if (mem_req) begin
          if (mem_q.size() == 0) begin
            check1("mem_req_unexpected", mem_req, 1'b0);
          end else begin
            m = mem_q[0];
            check1("mem_we", mem_we, m.we);
            check("mem_addr", mem_addr, m.addr);
            check("mem_wdata", mem_wdata, m.wdata);
            if (mem_ready) void'(mem_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_pat[6];
    bit g_d;
    bit g_i;
    int dgr;
    int hi;
    checks = 0;
    errors = 0;
    lat = 1;
    man_ready = 1'b0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    mem_arr[32'h100] = 32'hDEADBEEF;
    mem_arr[32'h200] = 32'hCAFEF00D;
    exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check1("rst_if_valid", if_valid, 1'b0);
    check1("rst_dm_valid", dm_valid, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    reset = 1'b0;

    // Single fetch with one-cycle memory latency.
    next_cyc();
    mem_q.push_back('{1'b0, 32'h100, 32'h0});
    if_q.push_back(32'hDEADBEEF);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check1("t1_if_gnt", if_gnt, 1'b1);
    check1("t1_dm_gnt", dm_gnt, 1'b0);
    next_cyc();
    if_req = 1'b0;
    @(negedge clk);
    check1("t1_mem_req", mem_req, 1'b1);
    check1("t1_stall_f_busy", stall_f, 1'b1);
    check1("t1_if_valid_early", if_valid, 1'b0);
    next_cyc();
    @(negedge clk);
    check1("t1_if_valid", if_valid, 1'b1);
    check1("t1_stall_f_valid", stall_f, 1'b0);
    check1("t1_mem_req_clr", mem_req, 1'b0);
    next_cyc();

    // Simultaneous requests: data write first, fetch granted in the dm_valid cycle.
    mem_q.push_back('{1'b1, 32'h40, 32'h12345678});
    mem_q.push_back('{1'b0, 32'h200, 32'h0});
    dm_q.push_back(32'h0);
    if_q.push_back(32'hCAFEF00D);
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
    @(negedge clk);
    check1("t2_dm_gnt", dm_gnt, 1'b1);
    check1("t2_if_gnt", if_gnt, 1'b0);
    check1("t2_stall_f", stall_f, 1'b1);
    check1("t2_stall_m", stall_m, 1'b0);
    next_cyc();
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    check1("t2_stall_m_busy", stall_m, 1'b1);
    check1("t2_no_gnt_busy", if_gnt, 1'b0);
    next_cyc();
    @(negedge clk);
    check1("t2_dm_valid", dm_valid, 1'b1);
    check1("t2_if_gnt_in_valid", if_gnt, 1'b1);
    check1("t2_stall_m_valid", stall_m, 1'b0);
    next_cyc();
    if_req = 1'b0;
    wait_drain("t2_drain");

    // Continuous contention: four data grants, then fetch, then data again.
    glog.delete();
    for (int k = 0; k < 4; k++) begin
      dm_q.push_back(32'h12345678);
      mem_q.push_back('{1'b0, 32'h40, 32'h0});
    end
    mem_q.push_back('{1'b0, 32'h100, 32'h0});
    mem_q.push_back('{1'b0, 32'h40, 32'h0});
    dm_q.push_back(32'h12345678);
    if_q.push_back(32'hDEADBEEF);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h100;
    dgr = 0;
    for (int c = 0; c < 30 && (dm_req || if_req); c++) begin
      @(negedge clk);
      g_d = dm_gnt;
      g_i = if_gnt;
      next_cyc();
      if (g_i) if_req = 1'b0;
      if (g_d) begin
        dgr++;
        if (dgr == 5) dm_req = 1'b0;
      end
    end
    check1("t3_all_granted", dm_req | if_req, 1'b0);
    wait_drain("t3_drain");
    check("t3_grant_count", glog.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < glog.size()) check1($sformatf("t3_grant_%0d", k), glog[k], exp_pat[k]);
    end

    // Five-cycle memory latency on a data read.
    lat = 5;
    mem_q.push_back('{1'b0, 32'h100, 32'h0});
    dm_q.push_back(32'hDEADBEEF);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    @(negedge clk);
    check1("t4_dm_gnt", dm_gnt, 1'b1);
    next_cyc();
    dm_req = 1'b0;
    hi = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check1("t4_stall_m", stall_m, 1'b1);
      check1("t4_no_valid", dm_valid, 1'b0);
      if (mem_req) hi++;
      next_cyc();
    end
    @(negedge clk);
    check1("t4_dm_valid", dm_valid, 1'b1);
    check1("t4_stall_m_clr", stall_m, 1'b0);
    check1("t4_mem_req_clr", mem_req, 1'b0);
    check("t4_req_cycles", hi, 32'd5);
    next_cyc();

    // Reset during a data write, then stray mem_ready pulses.
    mem_q.push_back('{1'b1, 32'h44, 32'h55AA55AA});
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'h55AA55AA;
    @(negedge clk);
    check1("t5_dm_gnt", dm_gnt, 1'b1);
    next_cyc();
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    check1("t5_busy", mem_req, 1'b1);
    next_cyc();
    #2;
    reset = 1'b1;
    #1;
    check1("t5_rst_mem_req", mem_req, 1'b0);
    check1("t5_rst_mem_we", mem_we, 1'b0);
    check("t5_rst_mem_addr", mem_addr, 32'h0);
    check("t5_rst_mem_wdata", mem_wdata, 32'h0);
    check("t5_rst_dm_rdata", dm_rdata, 32'h0);
    check("t5_rst_if_rdata", if_rdata, 32'h0);
    check1("t5_rst_stall_m", stall_m, 1'b0);
    mem_q.delete();
    next_cyc();
    man_ready = 1'b1;
    @(negedge clk);
    check1("t5_ready_in_rst", dm_valid, 1'b0);
    next_cyc();
    man_ready = 1'b0;
    reset = 1'b0;
    lat = 1;
    @(negedge clk);
    check1("t5_no_dm_valid", dm_valid, 1'b0);
    next_cyc();
    man_ready = 1'b1;
    @(negedge clk);
    check1("t6_idle_mem_req", mem_req, 1'b0);
    next_cyc();
    man_ready = 1'b0;
    @(negedge clk);
    check1("t6_no_dm_valid", dm_valid, 1'b0);
    check1("t6_no_if_valid", if_valid, 1'b0);
    check1("t6_no_mem_req", mem_req, 1'b0);
    next_cyc();
    mem_q.push_back('{1'b0, 32'h200, 32'h0});
    if_q.push_back(32'hCAFEF00D);
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    check1("t6_if_gnt_idle", if_gnt, 1'b1);
    next_cyc();
    if_req = 1'b0;
    wait_drain("t6_drain");

    repeat (3) next_cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
